// File: rtl/pipe_control_if.sv
// Decode-stage bus: instruction in from IF/ID plus stage controls, and the ID/EX control word out.
// The master modport drives instructions; the slave modport is the decode stage.
interface pipe_control_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      inst_i;
  logic             inst_valid_i;
  logic             stall_ext_i;
  logic             flush_i;
  logic [7:0]       ctrl_o;
  logic             branch_o;
  logic             bne_o;
  logic             jump_o;
  logic [5:0]       op_o;
  logic [REG_W-1:0] rs_o;
  logic [REG_W-1:0] rt_o;
  logic [REG_W-1:0] rd_o;
  logic [REG_W-1:0] wr_reg_o;
  logic [15:0]      imm_o;
  logic             valid_o;
  logic             illegal_o;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output inst_i, inst_valid_i, stall_ext_i, flush_i,
    input  ctrl_o, branch_o, bne_o, jump_o, op_o, rs_o, rt_o, rd_o, wr_reg_o,
           imm_o, valid_o, illegal_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  inst_i, inst_valid_i, stall_ext_i, flush_i,
    output ctrl_o, branch_o, bne_o, jump_o, op_o, rs_o, rt_o, rd_o, wr_reg_o,
           imm_o, valid_o, illegal_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_control.sv
// Registered MIPS-subset decode stage (ID/EX register) with load-use bubble insertion,
// external stall/flush handling and a saturating count of hazard bubbles.
module pipe_control #(
  parameter int unsigned REG_W     = 5,
  parameter bit          HAZARD_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pipe_control_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [5:0]       in_op;
  logic [REG_W-1:0] in_rs, in_rt, in_rd;
  logic [7:0]       dec_ctrl;
  logic             dec_br, dec_bne, dec_j, dec_known, use_rs, use_rt;
  logic             hazard_c, stall_c, load_bubble, load_dec;

  logic [7:0]       ctrl_q, ctrl_d;
  logic             branch_q, branch_d, bne_q, bne_d, jump_q, jump_d;
  logic [5:0]       op_q, op_d;
  logic [REG_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, wr_reg_q, wr_reg_d;
  logic [15:0]      imm_q, imm_d;
  logic             valid_q, valid_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_op = bus.inst_i[31:26];
  assign in_rs = REG_W'(bus.inst_i[25:21]);
  assign in_rt = REG_W'(bus.inst_i[20:16]);
  assign in_rd = REG_W'(bus.inst_i[15:11]);

  // Opcode decode: control word, transfer flags and which source fields are read.
  always_comb begin
    dec_ctrl  = 8'h00;
    dec_br    = 1'b0;
    dec_bne   = 1'b0;
    dec_j     = 1'b0;
    dec_known = 1'b1;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    case (in_op)
      OP_RTYPE:                  begin dec_ctrl = 8'h85; use_rs = 1'b1; use_rt = 1'b1; end
      OP_ADDI:                   begin dec_ctrl = 8'h88; use_rs = 1'b1; end
      OP_ORI, OP_ANDI, OP_SLTI:  begin dec_ctrl = 8'h8E; use_rs = 1'b1; end
      OP_LW:                     begin dec_ctrl = 8'hE8; use_rs = 1'b1; end
      OP_SW:                     begin dec_ctrl = 8'h18; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BEQ:  begin dec_ctrl = 8'h02; dec_br  = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BNE:  begin dec_ctrl = 8'h02; dec_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_J:    begin dec_ctrl = 8'h00; dec_j   = 1'b1; end
      default: dec_known = 1'b0;
    endcase
  end

  // Load-use: a load in the stage writes a register the incoming instruction reads.
  assign hazard_c = HAZARD_EN && valid_q && ctrl_q[5] && (wr_reg_q != '0) && bus.inst_valid_i &&
                    ((use_rs && (in_rs == wr_reg_q)) || (use_rt && (in_rt == wr_reg_q)));

  // Next-state: flush > external stall (hold) > hazard bubble > idle bubble > decode.
  always_comb begin
    ctrl_d      = ctrl_q;
    branch_d    = branch_q;
    bne_d       = bne_q;
    jump_d      = jump_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    wr_reg_d    = wr_reg_q;
    imm_d       = imm_q;
    valid_d     = valid_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    load_bubble = 1'b0;
    load_dec    = 1'b0;

    if (bus.flush_i) begin
      load_bubble = 1'b1;
    end else if (!bus.stall_ext_i) begin
      if (hazard_c) begin
        stall_c     = 1'b1;
        load_bubble = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else if (!bus.inst_valid_i || !dec_known) begin
        load_bubble = 1'b1;
      end else begin
        load_dec = 1'b1;
      end
    end

    if (load_bubble || load_dec) begin
      op_d      = in_op;
      rs_d      = in_rs;
      rt_d      = in_rt;
      rd_d      = in_rd;
      wr_reg_d  = dec_ctrl[0] ? in_rd : in_rt;
      imm_d     = bus.inst_i[15:0];
      ctrl_d    = load_dec ? dec_ctrl : 8'h00;
      branch_d  = load_dec && dec_br;
      bne_d     = load_dec && dec_bne;
      jump_d    = load_dec && dec_j;
      valid_d   = load_dec;
      // Only a real, unstalled, unflushed instruction with an unknown opcode flags illegal.
      illegal_d = load_bubble && !bus.flush_i && !hazard_c && bus.inst_valid_i && !dec_known;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      branch_q  <= 1'b0;
      bne_q     <= 1'b0;
      jump_q    <= 1'b0;
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wr_reg_q  <= '0;
      imm_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      branch_q  <= branch_d;
      bne_q     <= bne_d;
      jump_q    <= jump_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      wr_reg_q  <= wr_reg_d;
      imm_q     <= imm_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ctrl_o      = ctrl_q;
  assign bus.branch_o    = branch_q;
  assign bus.bne_o       = bne_q;
  assign bus.jump_o      = jump_q;
  assign bus.op_o        = op_q;
  assign bus.rs_o        = rs_q;
  assign bus.rt_o        = rt_q;
  assign bus.rd_o        = rd_q;
  assign bus.wr_reg_o    = wr_reg_q;
  assign bus.imm_o       = imm_q;
  assign bus.valid_o     = valid_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.stall_o     = stall_c;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: two instances (16-bit and 2-bit stall counters) share stimulus;
// a reference model pushes expectations, monitors pop and compare.
module tb_pipe_control;

  localparam bit HAZARD_EN = 1'b1;
  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, ANDI = 6'b001100,
                         SLTI = 6'b001010, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, J = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_control_if #(.REG_W(5), .CNT_W(16)) b16 ();
  pipe_control_if #(.REG_W(5), .CNT_W(2))  b2 ();

  pipe_control #(.REG_W(5), .HAZARD_EN(HAZARD_EN), .CNT_W(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .bus(b16));
  pipe_control #(.REG_W(5), .HAZARD_EN(HAZARD_EN), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(b2));

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [2:0]  flags;   // {beq, bne, j}
    logic        ill;
    logic [41:0] fields;  // {op, rs, rt, rd, wr, imm}
    int          cnt;
  } exp_t;

  logic [7:0] ctrl_tab [logic [5:0]];
  exp_t       exp_q[$];
  bit         stall_q[$];
  exp_t       st;
  int         cnt;
  bit         last_stall;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic iv, input logic sx, input logic fl);
    b16.inst_i = inst; b16.inst_valid_i = iv; b16.stall_ext_i = sx; b16.flush_i = fl;
    b2.inst_i  = inst; b2.inst_valid_i  = iv; b2.stall_ext_i  = sx; b2.flush_i  = fl;
  endtask

  // Reference model: one clock of the stage, expressed from the decode table and priority rules.
  task automatic step(input logic [31:0] inst, input logic iv, input logic sx, input logic fl);
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [7:0] c;
    bit known, urs, urt, hz;
    @(negedge clk);
    drive(inst, iv, sx, fl);
    op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
    known = ctrl_tab.exists(op);
    c   = known ? ctrl_tab[op] : 8'h00;
    urs = known && (op != J);
    urt = known && (op == R || op == SW || op == BEQ || op == BNE);
    hz  = HAZARD_EN && st.valid && st.ctrl[5] && (st.fields[20:16] != 5'd0) && iv &&
          ((urs && rs == st.fields[20:16]) || (urt && rt == st.fields[20:16]));
    last_stall = !fl && !sx && hz;
    stall_q.push_back(last_stall);
    if (fl || !sx) begin
      st.valid  = !fl && !hz && iv && known;
      st.ctrl   = st.valid ? c : 8'h00;
      st.flags  = {st.valid && op == BEQ, st.valid && op == BNE, st.valid && op == J};
      st.ill    = !fl && !hz && iv && !known;
      st.fields = {op, rs, rt, rd, (c[0] ? rd : rt), inst[15:0]};
    end
    if (last_stall) cnt++;
    st.cnt = cnt;
    exp_q.push_back(st);
  endtask

  // Present an instruction as IF/ID would: re-present once if the stage asked for a stall.
  task automatic present(input logic [31:0] inst);
    step(inst, 1'b1, 1'b0, 1'b0);
    if (last_stall) step(inst, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"},   64'({b16.valid_o, b16.ctrl_o, b16.branch_o, b16.bne_o, b16.jump_o, b16.illegal_o}), 64'd0);
    chk({tag, "_fld"},   64'({b16.op_o, b16.rs_o, b16.rt_o, b16.rd_o, b16.wr_reg_o, b16.imm_o}), 64'd0);
    chk({tag, "_stall"}, 64'({b16.stall_o, b2.stall_o}), 64'd0);
    chk({tag, "_cnt"},   64'({b16.stall_cnt_o, b2.stall_cnt_o}), 64'd0);
  endtask

  function automatic void model_reset();
    st = '{valid: 1'b0, ctrl: 8'h00, flags: 3'b000, ill: 1'b0, fields: 42'd0, cnt: 0};
    cnt = 0;
  endfunction

  // Assert reset asynchronously in the middle of a cycle where the stage is stalling.
  task automatic reset_mid(input logic [31:0] inst);
    @(negedge clk);
    drive(inst, 1'b1, 1'b0, 1'b0);
    stall_q.push_back(1'b1);
    #3 rst = 1'b1;
    #1 check_zero("rst_mid");
    @(posedge clk);
    #1 drive(32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  // Registered-output monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("valid_ctrl", 64'({b16.valid_o, b16.ctrl_o}), 64'({e.valid, e.ctrl}));
        chk("flags", 64'({b16.branch_o, b16.bne_o, b16.jump_o}), 64'(e.flags));
        chk("illegal", 64'(b16.illegal_o), 64'(e.ill));
        chk("cnt16", 64'(b16.stall_cnt_o), 64'(sat(e.cnt, 65535)));
        chk("cnt2", 64'(b2.stall_cnt_o), 64'(sat(e.cnt, 3)));
        chk("dut2_ctrl", 64'({b2.valid_o, b2.ctrl_o, b2.illegal_o}), 64'({e.valid, e.ctrl, e.ill}));
        if (e.valid)
          chk("fields", 64'({b16.op_o, b16.rs_o, b16.rt_o, b16.rd_o, b16.wr_reg_o, b16.imm_o}),
              64'(e.fields));
      end
    end
  end

  // Combinational stall monitor, sampled mid-cycle after inputs settle.
  initial begin
    bit s;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() != 0) begin
        s = stall_q.pop_front();
        chk("stall_o", 64'({b16.stall_o, b2.stall_o}), 64'({s, s}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ops [10];
    logic [31:0] inst;
    ops = '{R, ADDI, ORI, ANDI, SLTI, LW, SW, BEQ, BNE, J};
    ctrl_tab[R] = 8'h85;  ctrl_tab[ADDI] = 8'h88; ctrl_tab[ORI] = 8'h8E; ctrl_tab[ANDI] = 8'h8E;
    ctrl_tab[SLTI] = 8'h8E; ctrl_tab[LW] = 8'hE8; ctrl_tab[SW] = 8'h18; ctrl_tab[BEQ] = 8'h02;
    ctrl_tab[BNE] = 8'h02; ctrl_tab[J] = 8'h00;
    model_reset();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Every opcode once, no dependencies.
    present(rtype(5'd1, 5'd2, 5'd3));
    present(itype(ADDI, 5'd1, 5'd4, 16'h0010));
    present(itype(ORI,  5'd1, 5'd5, 16'h00F0));
    present(itype(ANDI, 5'd1, 5'd6, 16'h0F00));
    present(itype(SLTI, 5'd1, 5'd7, 16'hFFFF));
    present(itype(LW,   5'd1, 5'd8, 16'h0004));
    present(itype(SW,   5'd9, 5'd10, 16'h0008));
    present(itype(BEQ,  5'd1, 5'd2, 16'h0003));
    present(itype(BNE,  5'd1, 5'd2, 16'hFFFD));
    present({J, 26'h0ABCDEF});

    // Load-use: one bubble, then the add.
    present(itype(LW, 5'd1, 5'd2, 16'h0000));
    present(rtype(5'd2, 5'd4, 5'd3));
    // Load to $0 and destination-only overlap: no stall.
    present(itype(LW, 5'd1, 5'd0, 16'h0000));
    present(rtype(5'd0, 5'd0, 5'd3));
    present(itype(LW, 5'd1, 5'd5, 16'h0000));
    present(itype(ADDI, 5'd1, 5'd5, 16'h0001));
    // Back-to-back dependent loads.
    present(itype(LW, 5'd1, 5'd6, 16'h0000));
    present(itype(LW, 5'd6, 5'd7, 16'h0000));
    present(itype(LW, 5'd7, 5'd8, 16'h0000));

    // Flush after a branch, and flush colliding with a hazard.
    present(itype(BEQ, 5'd1, 5'd2, 16'h0004));
    step(rtype(5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b1);
    present(itype(LW, 5'd1, 5'd2, 16'h0000));
    step(rtype(5'd2, 5'd2, 5'd3), 1'b1, 1'b0, 1'b1);

    // External stall with sw in stage, then an illegal opcode.
    present(itype(SW, 5'd3, 5'd4, 16'h0010));
    repeat (3) step(rtype(5'd1, 5'd2, 5'd3), 1'b1, 1'b1, 1'b0);
    present(itype(6'b111111, 5'd1, 5'd2, 16'h0000));
    repeat (2) step(itype(6'b111111, 5'd1, 5'd2, 16'h0000), 1'b1, 1'b1, 1'b0);
    present(rtype(5'd1, 5'd2, 5'd3));

    // External stall colliding with a hazard: hold, then the hazard is seen after release.
    present(itype(LW, 5'd1, 5'd9, 16'h0000));
    step(rtype(5'd9, 5'd1, 5'd3), 1'b1, 1'b1, 1'b0);
    present(rtype(5'd9, 5'd1, 5'd3));

    // Push the 2-bit counter past saturation.
    for (int i = 0; i < 4; i++) begin
      present(itype(LW, 5'd1, 5'd11, 16'h0000));
      present(itype(SW, 5'd11, 5'd12, 16'h0000));
    end

    present(itype(LW, 5'd1, 5'd2, 16'h0000));
    reset_mid(rtype(5'd2, 5'd4, 5'd3));
    present(rtype(5'd1, 5'd2, 5'd3));

    // Randomized traffic over a small register file to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 11) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 9)];
      inst = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom())};
      step(inst, 1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 10),
           1'($urandom_range(0, 99) < 8));
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size() + stall_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
